mux_sel_pipe: RTL



---
 rtl/mux_sel_pkg.sv | 15 +
 rtl/mux_sel_pipe_if.sv | 16 +
 rtl/sel_skid_buf.sv | 41 ++++
 rtl/mux_sel_pipe.sv | 38 +++
 4 files changed

// File: rtl/mux_sel_pkg.sv
// mux_sel_pkg: shared defaults, operand beat type and the truncating shift-add
package mux_sel_pkg;
  localparam int WIDTH_D = 8;
  localparam int CNT_W_D = 16;
  localparam int MAX_W = 64;
  typedef struct packed {
    logic [WIDTH_D-1:0] a;
    logic [WIDTH_D-1:0] b;
    logic sel;
  } beat_t;
  // Evaluated at full width; callers truncate to their own WIDTH for modulo 2^WIDTH.
  function automatic logic [MAX_W-1:0] calc_x(input logic [MAX_W-1:0] b);
    return (b << 2) + MAX_W'(1);
  endfunction
endpackage

// File: rtl/mux_sel_pipe_if.sv
// mux_sel_pipe_if: operand/result handshake bundle for mux_sel_pipe
interface mux_sel_pipe_if #(parameter int WIDTH = 8, parameter int CNT_W = 16);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic in_sel;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_y;
  logic [CNT_W-1:0] sel_cnt;
  modport master (output in_valid, in_a, in_b, in_sel, out_ready,
                  input in_ready, out_valid, out_y, sel_cnt);
  modport slave (input in_valid, in_a, in_b, in_sel, out_ready,
                 output in_ready, out_valid, out_y, sel_cnt);
endinterface

// File: rtl/sel_skid_buf.sv
// sel_skid_buf: WIDTH-bit valid/ready register slice with a 1-entry skid
module sel_skid_buf #(parameter int WIDTH = 8) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  output logic o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic o_valid,
  input  logic i_ready,
  output logic [WIDTH-1:0] o_data
);
  logic r_valid, r_skid_valid;
  logic [WIDTH-1:0] r_data, r_skid;
  logic w_acc, w_cons;
  assign o_ready = !r_skid_valid && !rst;
  assign w_acc = i_valid && o_ready;
  assign w_cons = r_valid && i_ready;
  assign o_valid = r_valid;
  assign o_data = r_data;
  // Skid only fills while main is stalled, so main is always full when skid is.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data <= '0;
      r_skid_valid <= 1'b0;
      r_skid <= '0;
    end else if (!r_valid || w_cons) begin
      if (r_skid_valid) begin
        r_valid <= 1'b1;
        r_data <= r_skid;
        r_skid_valid <= 1'b0;
      end else begin
        r_valid <= w_acc;
        if (w_acc) r_data <= i_data;
      end
    end else if (w_acc) begin
      r_skid_valid <= 1'b1;
      r_skid <= i_data;
    end
  end
endmodule

// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe: registered y = sel ? ((b<<2)+1) : a with skid handshake.
// Optional SEL_STAT_EN adds a saturating count of accepted sel=1 beats.
module mux_sel_pipe
  import mux_sel_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int CNT_W = CNT_W_D
) (
  input logic clk,
  input logic rst,
  mux_sel_pipe_if.slave bus
);
  logic [WIDTH-1:0] w_x, w_y;
  assign w_x = WIDTH'(calc_x(MAX_W'(bus.in_b)));
  assign w_y = bus.in_sel ? w_x : bus.in_a;
  sel_skid_buf #(.WIDTH(WIDTH)) u_skid (
    .clk(clk),
    .rst(rst),
    .i_valid(bus.in_valid),
    .o_ready(bus.in_ready),
    .i_data(w_y),
    .o_valid(bus.out_valid),
    .i_ready(bus.out_ready),
    .o_data(bus.out_y)
  );
`ifdef SEL_STAT_EN
  logic w_acc;
  logic [CNT_W-1:0] r_sel_cnt;
  assign w_acc = bus.in_valid && bus.in_ready;
  always_ff @(posedge clk) begin
    if (rst) r_sel_cnt <= '0;
    else if (w_acc && bus.in_sel && r_sel_cnt != '1) r_sel_cnt <= r_sel_cnt + CNT_W'(1);
  end
  assign bus.sel_cnt = r_sel_cnt;
`else
  assign bus.sel_cnt = '0;
`endif
endmodule
